// File: rtl/coherent_bus_ctrl.sv
// N-core snooping coherence controller and round-robin arbiter for one shared single-port RAM.
// Optional event counters (perf_dtrans, perf_c2c, perf_ifetch) are built when COHERENT_BUS_PERF_EN is defined.
module coherent_bus_ctrl #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int IDXW = $clog2(CPUS)  // derived from CPUS; leave at its default
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*AW-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*AW-1:0]   daddr,
  input  logic [CPUS*AW-1:0]   dstore,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*AW-1:0]   iload,
  output logic [CPUS*AW-1:0]   dload,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*AW-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [AW-1:0]        ramstore,
  input  logic [AW-1:0]        ramload,
  input  logic [1:0]           ramstate
`ifdef COHERENT_BUS_PERF_EN
  ,
  output logic [31:0]          perf_dtrans,
  output logic [31:0]          perf_c2c,
  output logic [31:0]          perf_ifetch
`endif
);

  typedef enum logic [2:0] {ARB, SNOOP, RESOLVE, C2C, MEM, IFETCH} state_t;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t            state, state_n;
  logic [IDXW-1:0]   init, init_n, tgt, tgt_n, dptr, dptr_n, iptr, iptr_n;
  logic [AW-1:0]     saddr, saddr_n;
  logic              inv, inv_n;

  logic [IDXW-1:0]   dgrant, igrant, dirty_idx;
  logic [CPUS-1:0]   dirty_mask;

  // First set request at or after ptr, wrapping past CPUS-1 back to core 0.
  function automatic logic [IDXW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                               input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      idx = (int'(ptr) + i) % CPUS;
      if (!found && req[idx]) begin
        pick  = IDXW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDXW-1:0] lowest_set(input logic [CPUS-1:0] req);
    logic [IDXW-1:0] pick;
    pick = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (req[i]) pick = IDXW'(i);
    end
    return pick;
  endfunction

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
    return (int'(i) == CPUS - 1) ? '0 : i + 1'b1;
  endfunction

  assign dgrant     = rr_pick(cctrans, dptr);
  assign igrant     = rr_pick(iREN, iptr);
  assign dirty_mask = dWEN & ~(CPUS'(1) << init);
  assign dirty_idx  = lowest_set(dirty_mask);

  always_ff @(posedge CLK) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state <= ARB;
      init  <= '0;
      tgt   <= '0;
      dptr  <= '0;
      iptr  <= '0;
      saddr <= '0;
      inv   <= 1'b0;
    end else begin
      state <= state_n;
      init  <= init_n;
      tgt   <= tgt_n;
      dptr  <= dptr_n;
      iptr  <= iptr_n;
      saddr <= saddr_n;
      inv   <= inv_n;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_n     = state;
    init_n      = init;
    tgt_n       = tgt;
    dptr_n      = dptr;
    iptr_n      = iptr;
    saddr_n     = saddr;
    inv_n       = inv;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    if (state != ARB && state != IFETCH) begin
      ccwait       = '1;
      ccwait[init] = 1'b0;
    end

    unique case (state)
      ARB: begin
        // Data transactions always beat instruction fetches.
        if (|cctrans) begin
          init_n  = dgrant;
          saddr_n = daddr[dgrant*AW +: AW];
          inv_n   = ccwrite[dgrant];
          dptr_n  = wrap_inc(dgrant);
          state_n = SNOOP;
        end else if (|iREN) begin
          init_n  = igrant;
          iptr_n  = wrap_inc(igrant);
          state_n = IFETCH;
        end
      end

      SNOOP, RESOLVE: begin
        for (int k = 0; k < CPUS; k++) begin
          if (k != int'(init)) begin
            ccsnoopaddr[k*AW +: AW] = saddr;
            ccinv[k]                = inv;
          end
        end
        if (state == SNOOP) begin
          state_n = RESOLVE;
        end else if (|dirty_mask) begin
          tgt_n   = dirty_idx;
          state_n = C2C;
        end else begin
          state_n = MEM;
        end
      end

      C2C: begin
        // Dirty owner's data goes to the initiator and is written back to RAM at once.
        ramWEN                 = 1'b1;
        ramaddr                = daddr[tgt*AW +: AW];
        ramstore               = dstore[tgt*AW +: AW];
        dload[init*AW +: AW]   = dstore[tgt*AW +: AW];
        if (ramstate == RAM_ACCESS) begin
          dwait[tgt]  = 1'b0;
          dwait[init] = 1'b0;
        end
        if (!(cctrans[init] || dWEN[tgt])) state_n = ARB;
      end

      MEM: begin
        ramREN               = dREN[init];
        ramWEN               = dWEN[init];
        ramaddr              = daddr[init*AW +: AW];
        ramstore             = dstore[init*AW +: AW];
        dload[init*AW +: AW] = ramload;
        if (ramstate == RAM_ACCESS) dwait[init] = 1'b0;
        if (!cctrans[init]) state_n = ARB;
      end

      IFETCH: begin
        ramREN               = 1'b1;
        ramaddr              = iaddr[init*AW +: AW];
        iload[init*AW +: AW] = ramload;
        if (ramstate == RAM_ACCESS) iwait[init] = 1'b0;
        if (ramstate == RAM_ACCESS || !iREN[init]) state_n = ARB;
      end

      default: state_n = ARB;
    endcase
  end

`ifdef COHERENT_BUS_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_dtrans <= '0;
      perf_c2c    <= '0;
      perf_ifetch <= '0;
    end else begin
      if (state == ARB && state_n == SNOOP && !(&perf_dtrans)) perf_dtrans <= perf_dtrans + 32'd1;
      if (state == RESOLVE && state_n == C2C && !(&perf_c2c))  perf_c2c    <= perf_c2c + 32'd1;
      if (!(&iwait) && !(&perf_ifetch))                        perf_ifetch <= perf_ifetch + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Self-checking bench for coherent_bus_ctrl (CPUS=4): directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, snoop fan-out and data routing.
module tb_coherent_bus_ctrl;
  localparam int CPUS = 4;
  localparam int AW   = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic                CLK = 1'b0;
  logic                RST;
  logic [CPUS-1:0]     iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS*AW-1:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]     iwait, dwait, ccwait, ccinv;
  logic [CPUS*AW-1:0]  iload, dload, ccsnoopaddr;
  logic                ramREN, ramWEN;
  logic [AW-1:0]       ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;
`ifdef COHERENT_BUS_PERF_EN
  logic [31:0]         perf_dtrans, perf_c2c, perf_ifetch;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int mdptr, miptr;  // model round-robin pointers

  coherent_bus_ctrl #(.CPUS(CPUS), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef COHERENT_BUS_PERF_EN
    , .perf_dtrans(perf_dtrans), .perf_c2c(perf_c2c), .perf_ifetch(perf_ifetch)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int rr(input logic [CPUS-1:0] req, input int ptr);
    for (int i = 0; i < CPUS; i++) begin
      if (req[(ptr + i) % CPUS]) return (ptr + i) % CPUS;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] word(input logic [CPUS*AW-1:0] v, input int k);
    return v[k*AW +: AW];
  endfunction

  function automatic logic [1:0] stall_state();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? FREE : (r == 1) ? BUSY : ERROR;
  endfunction

  task automatic scramble_data();
    for (int k = 0; k < CPUS; k++) begin
      daddr[k*AW +: AW]  = $urandom;
      dstore[k*AW +: AW] = $urandom;
      iaddr[k*AW +: AW]  = $urandom;
    end
    ccwrite = 4'($urandom);
  endtask

  // One coherent transaction from ARB through completion; entered in an ARB cycle.
  task automatic dtrans(input logic [CPUS-1:0] dirty, input int words, input int busy);
    int              e, t;
    logic [CPUS-1:0] others;
    logic [AW-1:0]   exp_addr;
    e      = rr(cctrans, mdptr);
    others = 4'hF & ~(4'b1 << e);
    dWEN   = dirty & others;
    dREN   = 4'b1 << e;
    t      = -1;
    for (int k = 0; k < CPUS; k++) if (t < 0 && dWEN[k]) t = k;
    ramstate = BUSY;
    #1;
    check("arb_ccwait", ccwait, 0);
    check("arb_dwait", dwait, 4'hF);
    tick();
    check("snoop_ccwait", ccwait, others);
    check("snoop_ccinv", ccinv, ccwrite[e] ? others : 4'h0);
    for (int k = 0; k < CPUS; k++)
      check("snoop_addr", word(ccsnoopaddr, k), (k == e) ? 32'h0 : word(daddr, e));
    tick();
    check("resolve_ccwait", ccwait, others);
    check("resolve_ccinv", ccinv, ccwrite[e] ? others : 4'h0);
    tick();
    exp_addr = (t >= 0) ? word(daddr, t) : word(daddr, e);
    for (int w = 0; w < words; w++) begin
      for (int b = 0; b < busy; b++) begin
        ramstate = stall_state();
        #1;
        check("stall_dwait", dwait, 4'hF);
        check("stall_ramaddr", ramaddr, exp_addr);
        tick();
      end
      ramstate = ACCESS;
      #1;
      check("xfer_ccwait", ccwait, others);
      check("xfer_ramaddr", ramaddr, exp_addr);
      if (t >= 0) begin
        check("c2c_ramWEN", {ramREN, ramWEN}, 2'b01);
        check("c2c_ramstore", ramstore, word(dstore, t));
        check("c2c_dload", word(dload, e), word(dstore, t));
        check("c2c_dwait", dwait, 4'hF & ~((4'b1 << e) | (4'b1 << t)));
      end else begin
        check("mem_strobes", {ramREN, ramWEN}, 2'b10);
        check("mem_dload", word(dload, e), ramload);
        check("mem_dwait", dwait, 4'hF & ~(4'b1 << e));
      end
      if (w == words - 1) begin
        cctrans[e] = 1'b0;
        dWEN       = '0;
        dREN       = '0;
      end else begin
        ramload = ramload + 32'd1;
      end
      tick();
    end
    mdptr = (e + 1) % CPUS;
  endtask

  // One instruction fetch, entered in an ARB cycle with cctrans clear; late_pend arrives mid-fetch.
  task automatic ifetch(input int busy, input logic [CPUS-1:0] late_pend);
    int g;
    g = rr(iREN, miptr);
    ramstate = BUSY;
    #1;
    check("iarb_iwait", iwait, 4'hF);
    check("iarb_ccwait", ccwait, 0);
    tick();
    cctrans = cctrans | late_pend;
    for (int b = 0; b < busy; b++) begin
      ramstate = stall_state();
      #1;
      check("ifetch_stall_iwait", iwait, 4'hF);
      check("ifetch_ramaddr", {ramREN, ramaddr}, {1'b1, word(iaddr, g)});
      check("ifetch_ccwait", ccwait, 0);
      tick();
    end
    ramstate = ACCESS;
    ramload  = $urandom;
    #1;
    check("ifetch_iwait", iwait, 4'hF & ~(4'b1 << g));
    check("ifetch_iload", word(iload, g), ramload);
    check("ifetch_iload_other", word(iload, (g + 1) % CPUS), 32'h0);
    iREN[g] = 1'b0;
    tick();
    miptr = (g + 1) % CPUS;
  endtask

  initial begin
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    mdptr = 0; miptr = 0;
    tick(); tick();
    check("rst_iwait", iwait, 4'hF);
    check("rst_dwait", dwait, 4'hF);
    check("rst_ccwait", ccwait, 0);
    check("rst_ram", {ramREN, ramWEN, ramaddr}, 0);
`ifdef COHERENT_BUS_PERF_EN
    check("rst_perf", {perf_dtrans, perf_c2c}, 0);
`endif
    RST = 1'b0;

    // All four cores contend: grants rotate 0,1,2,3 then back to 0.
    scramble_data();
    cctrans = 4'b1111;
    for (int i = 0; i < 4; i++) dtrans(4'b0000, 1, 0);
    cctrans = 4'b1111;
    dtrans(4'b0000, 1, 0);

    // Core 2 BusRdX of 0x100 broadcasts an invalidate to the other three.
    cctrans = 4'b0100; ccwrite = 4'b0100; daddr[2*AW +: AW] = 32'h100;
    dtrans(4'b0000, 1, 0);

    // Cores 1 and 3 both dirty for initiator 0: core 1 responds.
    cctrans = 4'b0001; ccwrite = 4'b0000; dstore[1*AW +: AW] = 32'hDEADBEEF;
    dtrans(4'b1010, 1, 1);

    // Clean read from RAM with wait states before ACCESS.
    cctrans = 4'b0001; ramload = 32'h1234;
    dtrans(4'b0000, 1, 2);

    // Instruction fetches; then a data request arriving mid-fetch wins the next ARB.
    iREN = 4'b0101;
    ifetch(0, 4'b0000);
    ifetch(0, 4'b0000);
    iREN = 4'b0011;
    ifetch(2, 4'b0100);
    dtrans(4'b0000, 1, 0);
    ifetch(0, 4'b0000);
    iREN = '0;

    // Randomized traffic, including multi-word blocks and stalled RAM.
    for (int n = 0; n < 40; n++) begin
      scramble_data();
      ramload = $urandom;
      if ($urandom_range(0, 3) == 0 && cctrans == 0) begin
        iREN = 4'($urandom) | 4'b0001 << $urandom_range(0, 3);
        ifetch($urandom_range(0, 2), 4'b0000);
        iREN = '0;
      end else begin
        cctrans = cctrans | (4'b0001 << $urandom_range(0, 3)) | 4'($urandom);
        dtrans(4'($urandom), $urandom_range(1, 2), $urandom_range(0, 2));
      end
    end
    cctrans = '0;

    // Reset while in C2C: back to ARB with idle outputs, pointers cleared.
    scramble_data();
    cctrans = 4'b0001; dWEN = 4'b0010; dREN = 4'b0001; ramstate = BUSY;
    tick(); tick(); tick();
    #1;
    check("c2c_before_rst", ramWEN, 1'b1);
    RST = 1'b1;
    tick();
    check("midrst_waits", {iwait, dwait}, 8'hFF);
    check("midrst_ramWEN", ramWEN, 1'b0);
    check("midrst_ccwait", ccwait, 0);
`ifdef COHERENT_BUS_PERF_EN
    check("midrst_perf", {perf_dtrans, perf_c2c, perf_ifetch}, 0);
`endif
    RST = 1'b0; cctrans = '0; dWEN = '0; dREN = '0;
    mdptr = 0; miptr = 0;
    cctrans = 4'b1001;
    dtrans(4'b0000, 1, 0);
    cctrans = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
